// File: rtl/ro_sense_pkg.sv
// Shared definitions for the ring-oscillator sense counter.
// Holds the FSM state type, default parameter values and the synchronizer depth.
// Optional feature macro: RO_SENSE_AVG_EN (four back-to-back gate windows, averaged).
package ro_sense_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GATE,
    DRAIN,
    DONE
  } ro_state_t;

  localparam int unsigned GATE_CYCLES_DEF   = 1024;
  localparam int unsigned SETTLE_CYCLES_DEF = 8;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned SYNC_DEPTH        = 2;

`ifdef RO_SENSE_AVG_EN
  localparam int unsigned AVG_PASSES = 4;
`else
  localparam int unsigned AVG_PASSES = 1;
`endif

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronizer plus rising-edge detector for the asynchronous RO output.
// Ports:
//   i_Clk   system clock, rising edge
//   i_Rst   asynchronous active-high reset
//   i_Async RO output, asynchronous to i_Clk
//   o_Edge  one-cycle strobe on a synchronized 0->1 transition
module ro_sync_edge
  import ro_sense_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Edge
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], i_Async};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign o_Edge = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/ro_sense_counter.sv
// Ring-oscillator measurement front-end: enables one RO cell, counts its
// synchronized rising edges over a fixed gate window and reports the result
// with a one-cycle valid pulse.
// Ports:
//   i_Clk, i_Rst   clock and asynchronous active-high reset
//   i_Start        measurement request, level-sampled in IDLE only
//   i_Sel          RO select, captured on an accepted start
//   i_RO_Out       RO output (asynchronous)
//   o_Enable       RO enable (registered)
//   o_Sel          RO select (registered)
//   o_Busy         high in every state except IDLE
//   o_Valid        one-cycle pulse, o_Count/o_Overflow valid
//   o_Count        saturating edge count of the last window
//   o_Overflow     last window saturated the counter
// Optional feature macro: RO_SENSE_AVG_EN (gate repeated 4x, o_Count = sum>>2).
module ro_sense_counter
  import ro_sense_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Sel,
  input  logic             i_RO_Out,
  output logic             o_Enable,
  output logic             o_Sel,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Overflow
);

  // Phase counter must cover SETTLE, GATE and the 2-cycle DRAIN.
  localparam int unsigned PH_MAX0 = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_MAX  = (PH_MAX0 > 2) ? PH_MAX0 : 2;
  localparam int unsigned PH_W    = $clog2(PH_MAX);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ro_state_t        state, state_nxt;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             ro_edge;
  logic             settle_end, gate_end, drain_end, last_pass;

  ro_sync_edge u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_RO_Out),
    .o_Edge  (ro_edge)
  );

  assign settle_end = (phase == PH_W'(SETTLE_CYCLES - 1));
  assign gate_end   = (phase == PH_W'(GATE_CYCLES - 1));
  assign drain_end  = (phase == PH_W'(1));

`ifdef RO_SENSE_AVG_EN
  logic [1:0]       pass;
  logic [CNT_W+1:0] sum;
  assign last_pass = (pass == 2'(AVG_PASSES - 1));
`else
  assign last_pass = 1'b1;
`endif

  // Saturating increment; an edge seen while already saturated flags overflow.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (ro_edge) begin
      if (cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start) state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = GATE;
      GATE:    if (gate_end && last_pass) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Enable   <= 1'b0;
      o_Sel      <= 1'b0;
      o_Count    <= '0;
      o_Overflow <= 1'b0;
      phase      <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
`ifdef RO_SENSE_AVG_EN
      pass       <= '0;
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            o_Sel    <= i_Sel;
            o_Enable <= 1'b1;
            phase    <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
`ifdef RO_SENSE_AVG_EN
            pass     <= '0;
            sum      <= '0;
`endif
          end
        end
        SETTLE: phase <= settle_end ? '0 : phase + PH_W'(1);
        GATE: begin
          phase <= gate_end ? '0 : phase + PH_W'(1);
          ovf   <= ovf_nxt;
`ifdef RO_SENSE_AVG_EN
          // Each pass saturates on its own; the pass result (including this
          // cycle's edge) folds into the sum and the counter restarts.
          if (gate_end) begin
            sum  <= sum + {2'b00, cnt_nxt};
            cnt  <= '0;
            pass <= pass + 2'd1;
          end else begin
            cnt  <= cnt_nxt;
          end
`else
          cnt <= cnt_nxt;
`endif
          if (gate_end && last_pass) o_Enable <= 1'b0;
        end
        DRAIN: begin
          phase <= phase + PH_W'(1);
          if (drain_end) begin
`ifdef RO_SENSE_AVG_EN
            o_Count <= sum[CNT_W+1:2];
`else
            o_Count <= cnt;
`endif
            o_Overflow <= ovf;
          end
        end
        DONE:    phase <= '0;
        default: phase <= '0;
      endcase
    end
  end

  assign o_Busy  = (state != IDLE);
  assign o_Valid = (state == DONE);

endmodule

// File: tb/tb_ro_sense_counter.sv
module tb_ro_sense_counter;

`ifdef RO_SENSE_AVG_EN
  localparam int PASSES = 4;
`else
  localparam int PASSES = 1;
`endif
  localparam int EN_HI_A = 8 + PASSES * 64;
  localparam int LAT_A   = EN_HI_A + 3;
  localparam int SPACE_A = EN_HI_A + 4;
  localparam int EN_HI_B = 8 + PASSES * 128;
  localparam int LAT_B   = EN_HI_B + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        sel_in = 1'b0;
  logic        ro = 1'b0;
  int          ro_half = 0;
  int          ro_cnt = 0;

  logic        a_en, a_sel, a_busy, a_valid, a_ovf;
  logic [15:0] a_count;
  logic        b_en, b_sel, b_busy, b_valid, b_ovf;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ro_sense_counter #(.GATE_CYCLES(64), .SETTLE_CYCLES(8), .CNT_W(16)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_a), .i_Sel(sel_in), .i_RO_Out(ro),
    .o_Enable(a_en), .o_Sel(a_sel), .o_Busy(a_busy), .o_Valid(a_valid),
    .o_Count(a_count), .o_Overflow(a_ovf)
  );

  ro_sense_counter #(.GATE_CYCLES(128), .SETTLE_CYCLES(8), .CNT_W(4)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_b), .i_Sel(sel_in), .i_RO_Out(ro),
    .o_Enable(b_en), .o_Sel(b_sel), .o_Busy(b_busy), .o_Valid(b_valid),
    .o_Count(b_count), .o_Overflow(b_ovf)
  );

  // Square-wave RO, half period ro_half clocks, offset from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ro_half == 0) begin
        ro = 1'b0;
        ro_cnt = 0;
      end else if (ro_cnt == ro_half - 1) begin
        ro = ~ro;
        ro_cnt = 0;
      end else begin
        ro_cnt++;
      end
    end
  end

  // Starts one measurement and follows it to o_Valid. Cycle 1 is the first
  // sample after the accepting edge. vcyc = 0 means no o_Valid within max_cyc.
  task automatic measure(input bit use_b, input bit sel, input int en_hi, input int max_cyc,
                         output int vcyc, output bit en_ok, output int first_cnt);
    logic en, v;
    @(posedge clk); #1;
    sel_in = sel;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    vcyc = 0;
    en_ok = 1'b1;
    first_cnt = use_b ? int'(b_count) : int'(a_count);
    for (int c = 1; c <= max_cyc; c++) begin
      en = use_b ? b_en : a_en;
      v  = use_b ? b_valid : a_valid;
      if (en !== (c <= en_hi)) en_ok = 1'b0;
      if (v === 1'b1) begin
        vcyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({a_en, a_sel, a_busy, a_valid, a_ovf} !== 5'b0) begin
      errors++; $display("FAIL reset_a_flags: got %b want 00000", {a_en, a_sel, a_busy, a_valid, a_ovf});
    end
    checks++; if (a_count !== 16'd0) begin
      errors++; $display("FAIL reset_a_count: got %0d want 0", a_count);
    end
    checks++; if ({b_en, b_sel, b_busy, b_valid, b_ovf} !== 5'b0) begin
      errors++; $display("FAIL reset_b_flags: got %b want 00000", {b_en, b_sel, b_busy, b_valid, b_ovf});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_busy !== 1'b0 || a_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", a_busy, a_en);
    end
  endtask

  task automatic test_basic();
    int vcyc, fc;
    bit en_ok;
    ro_half = 4;
    repeat (20) @(posedge clk);
    measure(1'b0, 1'b1, EN_HI_A, LAT_A + 20, vcyc, en_ok, fc);
    checks++; if (vcyc !== LAT_A) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", vcyc, LAT_A);
    end
    checks++; if (a_count !== 16'd8) begin
      errors++; $display("FAIL basic_count: got %0d want 8", a_count);
    end
    checks++; if (a_ovf !== 1'b0 || a_sel !== 1'b1) begin
      errors++; $display("FAIL basic_ovf_sel: got ovf=%b sel=%b want 0 1", a_ovf, a_sel);
    end
    checks++; if (en_ok !== 1'b1) begin
      errors++; $display("FAIL basic_enable_window: got %b want 1", en_ok);
    end
    @(posedge clk); #1;
    checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_valid: valid=%b busy=%b want 0 0", a_valid, a_busy);
    end
  endtask

  task automatic test_zero();
    int vcyc, fc;
    bit en_ok;
    ro_half = 0;
    repeat (4) @(posedge clk);
    measure(1'b0, 1'b0, EN_HI_A, LAT_A + 20, vcyc, en_ok, fc);
    checks++; if (fc !== 8) begin
      errors++; $display("FAIL count_held_at_start: got %0d want 8", fc);
    end
    checks++; if (vcyc !== LAT_A) begin
      errors++; $display("FAIL zero_latency: got %0d want %0d", vcyc, LAT_A);
    end
    checks++; if (a_count !== 16'd0 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL zero_count: got %0d ovf=%b want 0 0", a_count, a_ovf);
    end
    checks++; if (a_sel !== 1'b0) begin
      errors++; $display("FAIL zero_sel: got %b want 0", a_sel);
    end
    checks++; if (en_ok !== 1'b1) begin
      errors++; $display("FAIL zero_enable_window: got %b want 1", en_ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int vcyc, fc;
    bit en_ok;
    ro_half = 2;
    repeat (4) @(posedge clk);
    measure(1'b1, 1'b1, EN_HI_B, LAT_B + 20, vcyc, en_ok, fc);
    checks++; if (vcyc !== LAT_B) begin
      errors++; $display("FAIL sat_latency: got %0d want %0d", vcyc, LAT_B);
    end
    checks++; if (b_count !== 4'd15) begin
      errors++; $display("FAIL sat_count: got %0d want 15", b_count);
    end
    checks++; if (b_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_overflow: got %b want 1", b_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_gate();
    int vcyc, fc;
    bit en_ok;
    bit seen;
    ro_half = 4;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (a_en !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_immediate: en=%b busy=%b want 0 0", a_en, a_busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT_A + 20; c++) begin
      @(posedge clk); #1;
      if (a_valid === 1'b1 || a_busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_no_valid: got activity=%b want 0", seen);
    end
    measure(1'b0, 1'b1, EN_HI_A, LAT_A + 20, vcyc, en_ok, fc);
    checks++; if (vcyc !== LAT_A || a_count !== 16'd8) begin
      errors++; $display("FAIL midreset_fresh: got lat=%0d cnt=%0d want %0d 8", vcyc, a_count, LAT_A);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int vcyc;
    bit busy_again;
    ro_half = 4;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    vcyc = 0;
    for (int c = 1; c <= LAT_A + 20; c++) begin
      if (c == 40) start_a = 1'b1;
      if (c == 41) start_a = 1'b0;
      if (a_valid === 1'b1) begin
        vcyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (vcyc !== LAT_A || a_count !== 16'd8) begin
      errors++; $display("FAIL ignore_start_meas: got lat=%0d cnt=%0d want %0d 8", vcyc, a_count, LAT_A);
    end
    busy_again = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (a_busy !== 1'b0) busy_again = 1'b1;
    end
    checks++; if (busy_again !== 1'b0) begin
      errors++; $display("FAIL ignore_start_no_restart: got %b want 0", busy_again);
    end
  endtask

  task automatic test_back_to_back();
    int v[3];
    int n;
    ro_half = 4;
    n = 0;
    v[0] = 0; v[1] = 0; v[2] = 0;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 3 * SPACE_A + 20; c++) begin
      if (a_valid === 1'b1) begin
        v[n] = c;
        checks++; if (a_count !== 16'd8) begin
          errors++; $display("FAIL b2b_count%0d: got %0d want 8", n, a_count);
        end
        n++;
        if (n == 3) begin
          start_a = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    checks++; if (v[0] !== LAT_A || v[1] !== LAT_A + SPACE_A || v[2] !== LAT_A + 2 * SPACE_A) begin
      errors++; $display("FAIL b2b_spacing: got %0d %0d %0d want %0d %0d %0d", v[0], v[1], v[2],
                         LAT_A, LAT_A + SPACE_A, LAT_A + 2 * SPACE_A);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: got busy=%b want 0", a_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_saturate();
    test_reset_mid_gate();
    test_ignore_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
